ysyx_23060332_ctrl: RTL
=======================

Name: ysyx_23060332_ctrl

Overview:
Multi-cycle sequencer for the NPC core. It steps each instruction through fetch, execute, optional memory access and writeback. It holds the current instruction stable for the decode/execute datapath and gates register-file writes and PC updates to a single commit cycle. It sits between the instruction-fetch interface, the combinational decode/execute path, the LSU and the register file.

Parameters:
RESET_PC, 32'h8000_0000, PC value loaded on reset
XLEN, 32, datapath/PC width
TIMEOUT_CYCLES, 255, wait limit for the watchdog (used only with CTRL_TIMEOUT_EN)

Ports:
clk  input  1  core clock
rst_n  input  1  asynchronous active-low reset
pc  output  XLEN  current PC; also the fetch address
ifu_req_valid  output  1  fetch request
ifu_rsp_valid  input  1  fetch data valid
inst_rdata  input  32  fetched instruction
inst_o  output  32  latched instruction to idu/exu
reg_wen_i  input  1  write enable from exu
jump_en_i  input  1  jump taken from exu
jump_addr_i  input  XLEN  jump target from exu
lsu_req_valid  output  1  memory access request
lsu_req_ready  input  1  LSU accepts the request
lsu_rsp_valid  input  1  LSU access done
reg_wen_o  output  1  gated register-file write enable
commit  output  1  one-cycle retire pulse
instret  output  32  retired-instruction counter
halted  output  1  sticky halt flag
err  output  1  sticky watchdog error (0 when the feature is off)

Behaviour:
- Reset (async, rst_n low): state=IDLE; pc=RESET_PC; inst_o=32'h0000_0013 (NOP); instret=0; all request, enable, commit, halted and err outputs = 0.
- Reset asserted mid-operation: all requests drop immediately; no commit occurs.
- States: IDLE, FETCH, EXEC, MEM, WB, HALT.
- IDLE: lasts one cycle, then FETCH.
- FETCH:
  - ifu_req_valid=1 and held stable until ifu_rsp_valid.
  - When ifu_rsp_valid is high: inst_o<=inst_rdata, go to EXEC.
  - ifu_rsp_valid in any other state is ignored.
- EXEC: one cycle; the exu evaluates inst_o. Next state:
  - inst_o==32'h0010_0073 (ebreak) -> HALT;
  - opcode 7'b0000011 (load) or 7'b0100011 (store) -> MEM;
  - otherwise -> WB.
- MEM:
  - lsu_req_valid=1 until a cycle with lsu_req_ready=1, then 0.
  - Then wait for lsu_rsp_valid. A response in the same cycle as acceptance counts. A response before acceptance is ignored.
  - Response received -> WB.
- WB: exactly one cycle.
  - commit=1.
  - reg_wen_o=reg_wen_i, forced 0 for store opcodes.
  - pc<=jump_en_i ? {jump_addr_i[XLEN-1:1],1'b0} : pc+4. PC wraps mod 2^XLEN.
  - instret<=instret+1, wrapping at 2^32.
  - Next state: FETCH.
- reg_wen_o and commit are 0 in every state except WB; pc changes only in WB.
- HALT: halted=1; no requests issued; pc, instret and inst_o frozen until reset.
- Best-case latency for a non-memory instruction: FETCH(1) + EXEC(1) + WB(1) = 3 cycles.

Optional Feature:
CTRL_TIMEOUT_EN:
- Defined: a wait counter resets on entry to FETCH or MEM and counts each cycle spent waiting there. If it reaches TIMEOUT_CYCLES without the awaited handshake, err=1 (sticky), halted=1, state=HALT, and the pending request drops.
- Undefined: no counter; err tied to 0; waits are unbounded.

Test Plan:
- Reset, then ifu_rsp_valid with addi x1,x0,5 (32'h0050_0093) on the first FETCH cycle -> commit high in cycle 3; reg_wen_o=1 only in that cycle; pc=8000_0004; instret=1.
- jal with jump_en_i=1, jump_addr_i=32'h8000_0101 -> pc=32'h8000_0100 after WB; reg_wen_o pulses.
- sw, lsu_req_ready delayed 3 cycles, rsp 2 cycles later -> lsu_req_valid high exactly 4 cycles; reg_wen_o=0 in WB; instret increments.
- lw, ready and rsp in the same cycle -> WB the next cycle; reg_wen_o=reg_wen_i.
- ebreak fetched -> halted=1 after EXEC; no further ifu_req_valid; pc unchanged for 20 cycles.
- rst_n pulsed low during MEM -> lsu_req_valid drops combinationally with reset; pc=RESET_PC; instret=0. With CTRL_TIMEOUT_EN and ifu_rsp_valid held low -> err=1 after 255 wait cycles.

Source files
------------

// File: rtl/ysyx_23060332_ctrl.sv
// ysyx_23060332_ctrl: multi-cycle instruction sequencer for the NPC core.
// Each instruction is stepped through FETCH -> EXEC -> [MEM] -> WB. The fetched
// instruction is latched on inst_o and held stable for decode/execute.
// Register-file writes and PC updates happen only in the single WB cycle.
//
// Ports:
//   clk, rst_n      core clock, asynchronous active-low reset
//   pc              current PC, also the fetch address
//   ifu_req_valid   fetch request (held until ifu_rsp_valid)
//   ifu_rsp_valid   fetch data valid; inst_rdata carries the instruction
//   inst_o          latched instruction for idu/exu
//   reg_wen_i       exu write enable
//   jump_en_i       exu jump taken
//   jump_addr_i     exu jump target
//   lsu_req_valid   memory request (dropped once lsu_req_ready is seen)
//   lsu_req_ready   LSU accepted the request
//   lsu_rsp_valid   LSU access complete
//   reg_wen_o       gated register-file write enable (WB only, never for stores)
//   commit          one-cycle retire pulse
//   instret         retired-instruction counter
//   halted          sticky halt flag (ebreak or watchdog)
//   err             sticky watchdog error
//
// Optional feature macro: CTRL_TIMEOUT_EN enables a wait watchdog on FETCH and
// MEM. Without it err is tied low and waits are unbounded.
module ysyx_23060332_ctrl #(
  parameter int unsigned     XLEN           = 32,
  parameter logic [XLEN-1:0] RESET_PC       = 32'h8000_0000,
  parameter int unsigned     TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] pc,
  output logic            ifu_req_valid,
  input  logic            ifu_rsp_valid,
  input  logic [31:0]     inst_rdata,
  output logic [31:0]     inst_o,
  input  logic            reg_wen_i,
  input  logic            jump_en_i,
  input  logic [XLEN-1:0] jump_addr_i,
  output logic            lsu_req_valid,
  input  logic            lsu_req_ready,
  input  logic            lsu_rsp_valid,
  output logic            reg_wen_o,
  output logic            commit,
  output logic [31:0]     instret,
  output logic            halted,
  output logic            err
);

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [6:0]  OP_LOAD  = 7'b0000011;
  localparam logic [6:0]  OP_STORE = 7'b0100011;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    EXEC,
    MEM,
    WB,
    HALT
  } state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] pc_q;
  logic [31:0]     inst_q;
  logic [31:0]     instret_q;
  logic            lsu_acc_q;
  logic            is_load, is_store, is_ebreak;
  logic            lsu_fire, lsu_done;
  logic            timeout;

  assign is_load   = (inst_q[6:0] == OP_LOAD);
  assign is_store  = (inst_q[6:0] == OP_STORE);
  assign is_ebreak = (inst_q == EBREAK);

  // A response only counts once the request has been accepted, either in an
  // earlier cycle or in this very cycle.
  assign lsu_fire = lsu_req_valid && lsu_req_ready;
  assign lsu_done = (lsu_acc_q || lsu_fire) && lsu_rsp_valid;

`ifdef CTRL_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wait_cnt;
  logic          err_q;

  // Counter is zero on the first cycle of FETCH/MEM; the last allowed waiting
  // cycle is the one where it reads TIMEOUT_CYCLES-1.
  assign timeout = (wait_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state != FETCH && state != MEM) wait_cnt <= '0;
      else                                wait_cnt <= wait_cnt + 1'b1;
      if ((state == FETCH && !ifu_rsp_valid && timeout) ||
          (state == MEM && !lsu_done && timeout))
        err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  always_comb begin
    state_nxt     = state;
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    commit        = 1'b0;
    reg_wen_o     = 1'b0;
    unique case (state)
      IDLE:  state_nxt = FETCH;
      FETCH: begin
        ifu_req_valid = 1'b1;
        if (ifu_rsp_valid) state_nxt = EXEC;
        else if (timeout)  state_nxt = HALT;
      end
      EXEC: begin
        if (is_ebreak)                state_nxt = HALT;
        else if (is_load || is_store) state_nxt = MEM;
        else                          state_nxt = WB;
      end
      MEM: begin
        lsu_req_valid = !lsu_acc_q;
        if (lsu_done)     state_nxt = WB;
        else if (timeout) state_nxt = HALT;
      end
      WB: begin
        commit    = 1'b1;
        reg_wen_o = reg_wen_i && !is_store;
        state_nxt = FETCH;
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pc_q      <= RESET_PC;
      inst_q    <= NOP;
      instret_q <= '0;
      lsu_acc_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == FETCH && ifu_rsp_valid) inst_q <= inst_rdata;
      if (state != MEM)  lsu_acc_q <= 1'b0;
      else if (lsu_fire) lsu_acc_q <= 1'b1;
      if (state == WB) begin
        pc_q      <= jump_en_i ? (jump_addr_i & ~XLEN'(1)) : pc_q + XLEN'(4);
        instret_q <= instret_q + 32'd1;
      end
    end
  end

  assign pc      = pc_q;
  assign inst_o  = inst_q;
  assign instret = instret_q;
  assign halted  = (state == HALT);

endmodule
